// File: rtl/exec_sequencer.sv
// exec_sequencer: a four-state instruction sequencer (IDLE -> DECODE -> EXEC -> WB).
// It takes one 16-bit instruction at a time and holds it in an internal register.
// The ALU and register-file addresses are driven from that register. A legal
// instruction is written back; an illegal opcode is dropped with a one-cycle pulse.
// Throughput is one instruction every four cycles.
module exec_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [7:0]       alu_result,
  output logic [3:0]       alu_opcode,
  output logic [3:0]       read_reg1,
  output logic [3:0]       read_reg2,
  output logic [3:0]       write_reg,
  output logic [7:0]       write_data,
  output logic             reg_write,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [3:0] OP_LAST_LEGAL = 4'b0100;  // add, sub, and, or, xor are 0..4

  state_t           state_reg;
  logic [15:0]      instr_reg;
  logic [7:0]       write_data_reg;
  logic [CNT_W-1:0] retired_reg;
  logic             reg_write_reg;
  logic             done_reg;
  logic             illegal_reg;
  logic             opcode_legal;

  // Opcode legality is judged on the latched instruction, never on the live input
  assign opcode_legal = (instr_reg[15:12] <= OP_LAST_LEGAL);

  // Handshake is purely a function of state so the requester sees it without a cycle of lag
  assign instr_ready = (state_reg == IDLE);

  // Field decode from the instruction register keeps the datapath stable while busy
  assign alu_opcode = instr_reg[15:12];
  assign write_reg  = instr_reg[11:8];
  assign read_reg1  = instr_reg[7:4];
  assign read_reg2  = instr_reg[3:0];

  assign write_data = write_data_reg;
  assign reg_write  = reg_write_reg;
  assign done       = done_reg;
  assign illegal    = illegal_reg;
  assign retired    = retired_reg;

  // Sequencer FSM with registered strobes; the async clear drops an in-flight writeback at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      instr_reg      <= '0;
      write_data_reg <= '0;
      retired_reg    <= '0;
      reg_write_reg  <= 1'b0;
      done_reg       <= 1'b0;
      illegal_reg    <= 1'b0;
    end else begin
      // Strobes default low and are raised only on the edge entering their single active cycle
      reg_write_reg <= 1'b0;
      done_reg      <= 1'b0;
      illegal_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (instr_valid) begin
            instr_reg <= instr;
            state_reg <= DECODE;
          end
        end
        DECODE: begin
          // Raising the illegal flag here makes it high for exactly the EXEC cycle
          illegal_reg <= ~opcode_legal;
          state_reg   <= EXEC;
        end
        EXEC: begin
          if (opcode_legal) begin
            write_data_reg <= alu_result;
            reg_write_reg  <= 1'b1;
            done_reg       <= 1'b1;
            // Count is updated alongside the done pulse; wraps naturally at 2^CNT_W
            retired_reg    <= retired_reg + CNT_W'(1);
            state_reg      <= WB;
          end else begin
            state_reg <= IDLE;
          end
        end
        WB: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: a 16-bit-counter instance plus a 4-bit-counter
// instance driven in lockstep. A register-file model in the bench supplies the ALU result.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic [7:0]  alu_result;

  logic        instr_ready, reg_write, done, illegal;
  logic [3:0]  alu_opcode, read_reg1, read_reg2, write_reg;
  logic [7:0]  write_data;
  logic [15:0] retired;

  logic        instr_ready4, reg_write4, done4, illegal4;
  logic [3:0]  alu_opcode4, read_reg14, read_reg24, write_reg4;
  logic [7:0]  write_data4;
  logic [3:0]  retired4;

  typedef struct {
    bit         ill;
    logic [3:0] rd;
    logic [7:0] data;
    int         acyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  rf[16];
  logic [15:0] ret_model;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_result(alu_result), .alu_opcode(alu_opcode),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
    .write_data(write_data), .reg_write(reg_write), .done(done),
    .illegal(illegal), .retired(retired)
  );

  exec_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready4), .alu_result(alu_result), .alu_opcode(alu_opcode4),
    .read_reg1(read_reg14), .read_reg2(read_reg24), .write_reg(write_reg4),
    .write_data(write_data4), .reg_write(reg_write4), .done(done4),
    .illegal(illegal4), .retired(retired4)
  );

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      default: return 8'hFF;
    endcase
  endfunction

  // ALU as seen by the DUT: operands come from the addresses it drives
  assign alu_result = alu_f(alu_opcode, rf[read_reg1], rf[read_reg2]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %-18s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %-18s value=%0h", tag, got);
    end
  endtask

  // Present an instruction, wait (bounded) for the IDLE cycle, and record the acceptance edge
  task automatic send(input logic [15:0] ins, input bit hold, output int acyc);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acyc = cyc;
    if (!hold) instr_valid = 1'b0;
    e.ill  = (ins[15:12] > 4'h4);
    e.rd   = ins[11:8];
    e.data = alu_f(ins[15:12], rf[ins[7:4]], rf[ins[3:0]]);
    e.acyc = acyc;
    sb.push_back(e);
    $display("send instr=%04h at cyc %0d", ins, acyc);
  endtask

  // Monitor: pops the scoreboard on every strobe cycle and models the register file
  initial begin
    exp_t e;
    for (int i = 0; i < 16; i++) rf[i] = 8'(2 * i + 2);
    ret_model = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ret_model = '0;
        sb.delete();
      end else if (reg_write || done || illegal) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {29'd0, reg_write, done, illegal}, 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.ill) begin
            check("illegal_pulse", illegal, 1);
            check("ill_no_write", {reg_write, done}, 0);
            check("ill_latency", cyc, e.acyc + 1);
          end else begin
            check("reg_write", reg_write, 1);
            check("done", done, 1);
            check("no_illegal", illegal, 0);
            check("write_reg", write_reg, e.rd);
            check("write_data", write_data, e.data);
            check("wb_latency", cyc, e.acyc + 2);
            ret_model = ret_model + 16'd1;
            check("retired", retired, ret_model);
            check("retired4", retired4, ret_model[3:0]);
            rf[e.rd] = e.data;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1;
    #1;
    // Reset state
    check("rst_ready", instr_ready, 1);
    check("rst_strobes", {reg_write, done, illegal}, 0);
    check("rst_fields", {alu_opcode, read_reg1, read_reg2, write_reg}, 0);
    check("rst_retired", retired, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Add 0312 with rf[1]=4, rf[2]=6 -> 0A
    check("add_operands", alu_f(4'h0, rf[1], rf[2]), 8'h0A);
    send(16'h0312, 1'b0, a0);

    // Illegal opcode: ready again on the cycle after the EXEC pulse
    send(16'h7312, 1'b0, a0);
    repeat (3) @(negedge clk);
    check("ill_ready_back", instr_ready, 1);
    check("ill_retired", retired, 1);

    // Back-to-back with valid held; the second uses the first's rd as a source
    send(16'h4334, 1'b1, a0);
    send(16'h1531, 1'b0, a1);
    check("b2b_spacing", a1 - a0, 4);
    repeat (4) @(negedge clk);
    check("b2b_retired", retired, 3);

    // Input stability: instr changes after acceptance must not reach the outputs
    send(16'h2678, 1'b0, a0);
    instr = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stable_fields", {alu_opcode, write_reg, read_reg1, read_reg2}, 16'h2678);
    end
    repeat (3) @(negedge clk);

    // Reset during EXEC: no writeback, everything cleared
    send(16'h0145, 1'b0, a0);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstx_ready", instr_ready, 1);
    check("rstx_reg_write", reg_write, 0);
    check("rstx_retired", retired, 0);
    check("rstx_fields", {alu_opcode, read_reg1, read_reg2, write_reg}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Reset during WB: reg_write drops without a clock edge
    send(16'h0312, 1'b0, a0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstwb_reg_write", reg_write, 0);
    check("rstwb_done", done, 0);
    check("rstwb_retired", retired, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Wrap: 16 legal retirements bring the 4-bit counter back to zero
    for (int n = 0; n < 16; n++) begin
      logic [15:0] ins;
      ins = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      send(ins, 1'b0, a0);
    end
    repeat (4) @(negedge clk);
    check("wrap_retired4", retired4, 0);
    check("wrap_retired16", retired, 16);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter: CNT_W, 16, width of the retired-instruction counter.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: instr  input  16  instruction; [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
REQ-005 Port: instr_valid  input  1  instr presented by the requester.
REQ-006 Port: instr_ready  output  1  sequencer can accept an instruction.
REQ-007 Port: alu_result  input  8  combinational ALU output for the current operands.
REQ-008 Port: alu_opcode  output  4  opcode driven to the ALU.
REQ-009 Port: read_reg1, read_reg2  output  4 each  register-file read addresses (rs1, rs2).
REQ-010 Port: write_reg  output  4  register-file write address (rd).
REQ-011 Port: write_data  output  8  register-file write data.
REQ-012 Port: reg_write  output  1  register-file write enable.
REQ-013 Port: done  output  1  one-cycle pulse when an instruction retires with writeback.
REQ-014 Port: illegal  output  1  one-cycle pulse when an instruction is dropped for illegal opcode.
REQ-015 Port: retired  output  CNT_W  count of instructions retired with writeback.

Function
REQ-016 FSM states: IDLE, DECODE, EXEC, WB; exactly one active at a time.
REQ-017 instr_ready = 1 only in IDLE; combinational from state.
REQ-018 IDLE: when instr_valid && instr_ready at posedge, latch instr into internal instruction register and go to DECODE; otherwise stay in IDLE.
REQ-019 From the latch edge until return to IDLE, alu_opcode, read_reg1, read_reg2 and write_reg are driven from the latched instruction; changes on instr are ignored.
REQ-020 DECODE: unconditionally go to EXEC (one cycle for register read and ALU settle).
REQ-021 Legal opcodes: 4'b0000 add, 4'b0001 sub, 4'b0010 and, 4'b0011 or, 4'b0100 xor; all others illegal.
REQ-022 EXEC with legal opcode: capture alu_result into write_data register; go to WB.
REQ-023 EXEC with illegal opcode: no capture; illegal = 1 for that cycle; go to IDLE; reg_write stays 0.
REQ-024 WB: reg_write = 1 and done = 1 for exactly this one cycle; write_reg = rd, write_data = captured result; retired increments by 1; go to IDLE.
REQ-025 reg_write, done and illegal are 0 in every state and cycle except those in REQ-023/REQ-024.
REQ-026 Latency: legal instruction accepted at edge N has reg_write high during cycle N+3; next acceptance is possible at edge N+4 (throughput one instruction per 4 cycles).
REQ-027 retired wraps modulo 2^CNT_W (all-ones + 1 = 0); no saturation, no flag.
REQ-028 rd equal to rs1 or rs2 is allowed; operands are the pre-write register values.
REQ-029 instr_valid held high continuously: a new instruction is accepted on every IDLE cycle; the requester must change instr after each acceptance.

Reset
REQ-030 rst_n low asynchronously forces state IDLE, instruction register 0, write_data 0, retired 0.
REQ-031 During and immediately after reset: instr_ready = 1, reg_write = 0, done = 0, illegal = 0, alu_opcode/read_reg1/read_reg2/write_reg = 0.
REQ-032 Reset asserted in any state aborts the instruction in flight with no writeback and no count change beyond clearing; reg_write falls without waiting for a clock edge.
REQ-033 First acceptance possible at the first posedge with rst_n high.

Verification
REQ-034 Add: instr=16'h0312 (rd=3, rs1=1, rs2=2), alu_result=8'h0A -> reg_write high 3 cycles after acceptance, write_reg=3, write_data=8'h0A, done pulse, retired=1.
REQ-035 Illegal: instr=16'h7312 -> illegal pulse in EXEC (2 cycles after acceptance), no reg_write, retired unchanged, instr_ready back high next cycle.
REQ-036 Back-to-back: instr_valid held high with xor then sub -> acceptances 4 cycles apart, two WB pulses, retired=2.
REQ-037 Reset mid-op: rst_n low during EXEC of 16'h0145 -> reg_write never asserts, retired=0, instr_ready=1 while reset asserted.
REQ-038 Wrap: CNT_W=4, 16 legal instructions retired -> retired returns to 0 on the 16th done pulse.
REQ-039 Input stability: change instr in DECODE/EXEC -> alu_opcode, read_reg1/2, write_reg keep latched values.
